// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and helpers for the bit-serial word adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sas_state_t;

  localparam int W_MAX = 32;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int clog2w(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 6; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Operand and result handshakes of the serial adder sequencer.
interface serial_add_sequencer_if #(
  parameter int W = 4
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, op_a, op_b, op_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  // Sequencer side.
  modport slave (
    input  in_valid, op_a, op_b, op_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Feeds a registered 1-bit full adder LSB-first and reassembles the word result.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_add_sequencer_if.slave  bus,
  output logic                   fa_rstn,
  output logic                   fa_a,
  output logic                   fa_b,
  output logic                   fa_cin,
  input  logic                   fa_sum,
  input  logic                   fa_cout
);

  localparam int IDX_W = clog2w(W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

  sas_state_t       state_q, state_d;
  logic [W-1:0]     a_sh_q, b_sh_q, sum_sh_q, out_sum_q;
  logic             cin_q, out_cout_q;
  logic [IDX_W-1:0] idx_q;
  logic             in_ready, out_valid;

  // The adder's reset follows ours without a register so it drops with rst.
  assign fa_rstn       = ~rst;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshakes and the bit presented to the adder.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_cin    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        fa_a   = a_sh_q[0];
        fa_b   = b_sh_q[0];
        // Bit 0 takes the word carry; later bits take the adder's own registered carry.
        fa_cin = (idx_q == '0) ? cin_q : fa_cout;
        if (idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand shifting and result collection; sums arrive one clk behind their bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      cin_q      <= 1'b0;
      idx_q      <= '0;
      sum_sh_q   <= '0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_q <= bus.op_a;
            b_sh_q <= bus.op_b;
            cin_q  <= bus.op_cin;
            idx_q  <= '0;
          end
        end
        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          idx_q  <= idx_q + 1'b1;
          // The first RUN clk has no sum yet; bit 0's sum shows up on the second.
          if (idx_q != '0) sum_sh_q <= {fa_sum, sum_sh_q[W-1:1]};
        end
        DRAIN: begin
          sum_sh_q   <= {fa_sum, sum_sh_q[W-1:1]};
          out_sum_q  <= {fa_sum, sum_sh_q[W-1:1]};
          out_cout_q <= fa_cout;
        end
        default: ;
      endcase
    end
  end

endmodule
